// File: rtl/zone_scheduler.sv
// Irrigation zone scheduler: grants one of seven zones round-robin and
// drives a demux (selector S, data in) through SELECT, WATER and GAP phases.
module zone_scheduler #(
   parameter int unsigned WATER_TIME = 16,
   parameter int unsigned GAP_TIME   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       abort,
   input  logic [6:0] req,
   output logic [2:0] S,
   output logic       in,
   output logic       busy,
   output logic       zone_done
);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      WATER,
      GAP
   } state_t;

   localparam logic [15:0] WATER_LOAD = 16'(WATER_TIME - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(GAP_TIME - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] timer;
   logic [15:0] timer_next;
   logic [2:0]  ptr;
   logic [2:0]  ptr_next;
   logic [2:0]  s_next;
   logic        in_next;
   logic        busy_next;
   logic        done_next;

   logic        pending;
   logic        stop;
   logic [2:0]  grant;
   logic        found;
   logic [3:0]  cand;

   assign pending = enable & (|req);
   assign stop    = abort | ~enable;

   // Round-robin search starting just after the last completed zone.
   always_comb begin
      grant = 3'd0;
      found = 1'b0;
      cand  = 4'd0;
      for (int i = 1; i <= 7; i++) begin
         cand = {1'b0, ptr} + 4'(i);
         if (cand >= 4'd7) begin
            cand = cand - 4'd7;
         end
         if (!found && req[cand[2:0]]) begin
            grant = cand[2:0];
            found = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_next = state;
      timer_next = timer;
      ptr_next   = ptr;
      s_next     = S;
      in_next    = in;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            s_next  = 3'd0;
            in_next = 1'b0;
            if (!abort && pending) begin
               s_next     = grant + 3'd1;
               state_next = SELECT;
            end
         end
         SELECT: begin
            if (stop) begin
               s_next     = 3'd0;
               in_next    = 1'b0;
               timer_next = 16'd0;
               state_next = IDLE;
            end else begin
               in_next    = 1'b1;
               timer_next = WATER_LOAD;
               state_next = WATER;
            end
         end
         WATER: begin
            if (stop) begin
               s_next     = 3'd0;
               in_next    = 1'b0;
               timer_next = 16'd0;
               state_next = IDLE;
            end else if (timer == 16'd0) begin
               s_next     = 3'd0;
               in_next    = 1'b0;
               done_next  = 1'b1;
               ptr_next   = S - 3'd1;
               timer_next = GAP_LOAD;
               state_next = GAP;
            end else begin
               timer_next = timer - 16'd1;
            end
         end
         GAP: begin
            s_next  = 3'd0;
            in_next = 1'b0;
            if (stop) begin
               timer_next = 16'd0;
               state_next = IDLE;
            end else if (timer == 16'd0) begin
               if (pending) begin
                  s_next     = grant + 3'd1;
                  state_next = SELECT;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer - 16'd1;
            end
         end
         default: begin
            s_next     = 3'd0;
            in_next    = 1'b0;
            timer_next = 16'd0;
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   // State, timer, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= 16'd0;
         ptr       <= 3'd6;
         S         <= 3'd0;
         in        <= 1'b0;
         busy      <= 1'b0;
         zone_done <= 1'b0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         ptr       <= ptr_next;
         S         <= s_next;
         in        <= in_next;
         busy      <= busy_next;
         zone_done <= done_next;
      end
   end

endmodule
